mdl_mlkem_intt128_gs_butterfly: RTL and testbench
=================================================

// Module: mdl_mlkem_intt128_gs_butterfly
// PURPOSE
//  Pipelined Gentleman-Sande butterfly for the ML-KEM 128-point inverse NTT. It is the INTT
//  counterpart of the forward NTT datapath: a'=(a+b) mod q, b'=((a-b) mod q)*zeta mod q.
//  Sits between the INTT coefficient-RAM read port and write-back port.
//  Uses a valid/ready stream handshake with backpressure.
// PARAMETERS
//  PRM_KYBER_Q       12'd3329  modulus q
//  PRM_KYBER_NINV    12'd3303  128^-1 mod q, final-layer scale (used only with INTT_SCALE_EN)
// PORTS
//  iClk     in   1   clock, all state on rising edge
//  iRst     in   1   synchronous reset, active-high
//  iValid   in   1   input beat valid
//  oReady   out  1   block can accept a beat this cycle
//  iA       in   12  coefficient a, range [0,q-1]
//  iB       in   12  coefficient b, range [0,q-1]
//  iZeta    in   12  twiddle, range [0,q-1], plain (non-Montgomery) domain
//  iScale   in   1   last-layer beat: multiply both outputs by NINV (ignored without INTT_SCALE_EN)
//  oValid   out  1   output beat valid
//  iReady   in   1   downstream accepts output beat
//  oA       out  12  a' in [0,q-1]
//  oB       out  12  b' in [0,q-1]
//  oBusy    out  1   any pipeline stage holds a valid beat
// BEHAVIOUR
//  - Reset: all stage valid flags=0; oValid=0, oA=0, oB=0, oBusy=0. oReady is 1 in the first
//    cycle after reset.
//  - Pipeline enable: en = ~oValid | iReady. All stages advance together when en=1; all hold when en=0.
//    oReady = en, combinational.
//  - An input beat is accepted iff iValid & oReady. An output beat is transferred iff oValid & iReady.
//  - Bubbles propagate as valid=0 stages. There is no skid buffer.
//  - S1: sum=iA+iB (13b), a'=sum>=q ? sum-q : sum; d=iA-iB (13b signed), d<0 ? d+q : d. Register a', d, zeta.
//  - S2: p=d*zeta, full 24-bit unsigned product registered; a' delayed alongside.
//  - S3: b'=p mod q, exact full reduction to [0,q-1] (result never equals q).
//  - Latency: 3 enabled cycles from acceptance to oValid without the macro, 4 with it.
//    With no stalls, throughput is 1 beat/cycle.
//  - Order is strictly preserved. Stalls never drop or duplicate a beat. oA/oB hold stable while
//    oValid=1 and iReady=0.
//  - Simultaneous accept and output transfer in one cycle is legal: full-rate streaming.
//  - iRst mid-stream: all in-flight beats are discarded. Nothing appears on the output after reset
//    deasserts until new inputs are accepted.
//  - Out-of-range inputs (>=q) give unspecified oA/oB data. Handshake and ordering are unaffected.
// CONFIGURATION
//  INTT_SCALE_EN defined:
//    - Adds S4. When the beat's iScale=1, S4 computes oA=a'*NINV mod q and oB=b'*NINV mod q.
//      When iScale=0, S4 passes a'/b' through.
//    - iScale is carried with the beat. Latency is 4 for every beat regardless of iScale.
//  INTT_SCALE_EN undefined:
//    - No S4 and no NINV multipliers. iScale is unused. Latency is 3.
// TESTING
//  1. a=5,b=3,zeta=1 -> oA=8, oB=2 after 3 cycles (4 with macro), oValid=1 for one cycle with iReady=1.
//  2. a=3,b=5,zeta=1 -> oA=8, oB=3327 (negative wrap). a=3328,b=3328,zeta=7 -> oA=3327, oB=0.
//  3. a=0,b=1,zeta=3328 -> oA=1, oB=1. a=10,b=0,zeta=17 -> oA=10, oB=170.
//  4. 8 back-to-back beats, iReady low for 3 cycles mid-stream -> oReady low while full,
//     outputs in order, none lost or repeated, 8 transfers total.
//  5. 2 beats in flight, iRst=1 one cycle -> next cycle oValid=0, oBusy=0, oReady=1;
//     no stale beat is emitted afterwards.
//  6. (INTT_SCALE_EN) a=1,b=0,zeta=1,iScale=1 -> oA=3303, oB=3303. Same beat with iScale=0 -> oA=1, oB=1.

Source files
------------

// File: rtl/mdl_mlkem_intt128_gs_butterfly.sv
// Pipelined Gentleman-Sande butterfly for the ML-KEM inverse NTT: a'=(a+b) mod q, b'=((a-b) mod q)*zeta mod q.
// Define INTT_SCALE_EN to add a fourth stage that can scale both outputs by 128^-1 mod q.
module mdl_mlkem_intt128_gs_butterfly #(
  parameter logic [11:0] PRM_KYBER_Q    = 12'd3329,
  parameter logic [11:0] PRM_KYBER_NINV = 12'd3303
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  output logic        oReady,
  input  logic [11:0] iA,
  input  logic [11:0] iB,
  input  logic [11:0] iZeta,
  input  logic        iScale,
  output logic        oValid,
  input  logic        iReady,
  output logic [11:0] oA,
  output logic [11:0] oB,
  output logic        oBusy
);

  // Barrett constant floor(2^24/q); the quotient estimate is short by at most 2
  localparam logic [13:0] BARRETT_M = 14'(32'd16777216 / 32'(PRM_KYBER_Q));

  function automatic logic [11:0] mod_q(input logic [23:0] x);
    logic [37:0] prod;
    logic [13:0] quo;
    logic [25:0] rem;
    prod = 38'(x) * 38'(BARRETT_M);
    quo  = 14'(prod >> 24);
    rem  = 26'(x) - (26'(quo) * 26'(PRM_KYBER_Q));
    if (rem >= 26'(PRM_KYBER_Q)) rem = rem - 26'(PRM_KYBER_Q);
    if (rem >= 26'(PRM_KYBER_Q)) rem = rem - 26'(PRM_KYBER_Q);
    return rem[11:0];
  endfunction

  logic        en;
  logic [12:0] sum_s1, diff_s1;

  logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [11:0] a1_q, a1_d, d1_q, d1_d, z1_q, z1_d;
  logic [23:0] p2_q, p2_d;
  logic [11:0] a2_q, a2_d;
  logic [11:0] a3_q, a3_d, b3_q, b3_d;

`ifdef INTT_SCALE_EN
  logic        sc1_q, sc1_d, sc2_q, sc2_d, sc3_q, sc3_d;
  logic        v4_q, v4_d;
  logic [11:0] a4_q, a4_d, b4_q, b4_d;

  assign oValid = v4_q;
  assign oA     = a4_q;
  assign oB     = b4_q;
  assign oBusy  = v1_q | v2_q | v3_q | v4_q;
`else
  logic              unused_scale;
  localparam logic [11:0] UNUSED_NINV = PRM_KYBER_NINV;

  assign unused_scale = iScale ^ UNUSED_NINV[0];
  assign oValid = v3_q;
  assign oA     = a3_q;
  assign oB     = b3_q;
  assign oBusy  = v1_q | v2_q | v3_q;
`endif

  // the whole pipe moves as one; a full pipe only advances when the output drains
  assign en     = ~oValid | iReady;
  assign oReady = en;

  always_comb begin
    sum_s1  = {1'b0, iA} + {1'b0, iB};
    diff_s1 = {1'b0, iA} - {1'b0, iB};
    if (sum_s1 >= 13'(PRM_KYBER_Q)) sum_s1 = sum_s1 - 13'(PRM_KYBER_Q);
    if (diff_s1[12]) diff_s1 = diff_s1 + 13'(PRM_KYBER_Q);

    v1_d = v1_q; a1_d = a1_q; d1_d = d1_q; z1_d = z1_q;
    v2_d = v2_q; p2_d = p2_q; a2_d = a2_q;
    v3_d = v3_q; a3_d = a3_q; b3_d = b3_q;
`ifdef INTT_SCALE_EN
    sc1_d = sc1_q; sc2_d = sc2_q; sc3_d = sc3_q;
    v4_d  = v4_q;  a4_d  = a4_q;  b4_d  = b4_q;
`endif

    // data registers only load behind a valid beat so bubbles leave them untouched
    if (en) begin
      v1_d = iValid;
      if (iValid) begin
        a1_d = sum_s1[11:0];
        d1_d = diff_s1[11:0];
        z1_d = iZeta;
`ifdef INTT_SCALE_EN
        sc1_d = iScale;
`endif
      end
      v2_d = v1_q;
      if (v1_q) begin
        p2_d = 24'(d1_q) * 24'(z1_q);
        a2_d = a1_q;
`ifdef INTT_SCALE_EN
        sc2_d = sc1_q;
`endif
      end
      v3_d = v2_q;
      if (v2_q) begin
        a3_d = a2_q;
        b3_d = mod_q(p2_q);
`ifdef INTT_SCALE_EN
        sc3_d = sc2_q;
`endif
      end
`ifdef INTT_SCALE_EN
      v4_d = v3_q;
      if (v3_q) begin
        a4_d = sc3_q ? mod_q(24'(a3_q) * 24'(PRM_KYBER_NINV)) : a3_q;
        b4_d = sc3_q ? mod_q(24'(b3_q) * 24'(PRM_KYBER_NINV)) : b3_q;
      end
`endif
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      v1_q <= 1'b0; a1_q <= '0; d1_q <= '0; z1_q <= '0;
      v2_q <= 1'b0; p2_q <= '0; a2_q <= '0;
      v3_q <= 1'b0; a3_q <= '0; b3_q <= '0;
`ifdef INTT_SCALE_EN
      sc1_q <= 1'b0; sc2_q <= 1'b0; sc3_q <= 1'b0;
      v4_q  <= 1'b0; a4_q  <= '0;   b4_q  <= '0;
`endif
    end else begin
      v1_q <= v1_d; a1_q <= a1_d; d1_q <= d1_d; z1_q <= z1_d;
      v2_q <= v2_d; p2_q <= p2_d; a2_q <= a2_d;
      v3_q <= v3_d; a3_q <= a3_d; b3_q <= b3_d;
`ifdef INTT_SCALE_EN
      sc1_q <= sc1_d; sc2_q <= sc2_d; sc3_q <= sc3_d;
      v4_q  <= v4_d;  a4_q  <= a4_d;  b4_q  <= b4_d;
`endif
    end
  end

endmodule

// File: tb/tb_mdl_mlkem_intt128_gs_butterfly.sv
// Directed bench for the INTT GS butterfly: arithmetic vectors, latency, backpressure and mid-stream reset.
module tb_mdl_mlkem_intt128_gs_butterfly;

`ifdef INTT_SCALE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [11:0] iA, iB, iZeta;
  logic        iScale;
  logic        oValid;
  logic        iReady;
  logic [11:0] oA, oB;
  logic        oBusy;

  int compared   = 0;
  int mismatched = 0;

  mdl_mlkem_intt128_gs_butterfly dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iValid (iValid),
    .oReady (oReady),
    .iA     (iA),
    .iB     (iB),
    .iZeta  (iZeta),
    .iScale (iScale),
    .oValid (oValid),
    .iReady (iReady),
    .oA     (oA),
    .oB     (oB),
    .oBusy  (oBusy)
  );

  always #5 iClk = ~iClk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int a, input int b, input int z, input logic sc);
    iValid = 1'b1;
    iA     = 12'(a);
    iB     = 12'(b);
    iZeta  = 12'(z);
    iScale = sc;
  endtask

  // one isolated beat: checks acceptance, latency, both results and a single-cycle oValid
  task automatic runBeat(input string tag, input int a, input int b, input int z, input logic sc,
                         input int exp_a, input int exp_b);
    int cyc;
    iReady = 1'b1;
    applyStimulus(a, b, z, sc);
    #1;
    checkOutput({tag, "_ready"}, 32'(oReady), 32'd1);
    step();
    iValid = 1'b0;
    cyc = 0;
    while (oValid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(LAT - 1));
    checkOutput({tag, "_oA"}, 32'(oA), 32'(exp_a));
    checkOutput({tag, "_oB"}, 32'(oB), 32'(exp_b));
    step();
    checkOutput({tag, "_oneshot"}, 32'(oValid), 32'd0);
  endtask

  initial begin
    int sent, rcvd, seen;
    logic [11:0] held_a;
    logic stalled_prev;

    iRst = 1'b1; iValid = 1'b0; iA = '0; iB = '0; iZeta = '0; iScale = 1'b0; iReady = 1'b1;
    step(); step();
    iRst = 1'b0;
    #1;
    checkOutput("reset_oValid", 32'(oValid), 32'd0);
    checkOutput("reset_oA", 32'(oA), 32'd0);
    checkOutput("reset_oB", 32'(oB), 32'd0);
    checkOutput("reset_oBusy", 32'(oBusy), 32'd0);
    checkOutput("reset_oReady", 32'(oReady), 32'd1);
    step();

    runBeat("basic",    5,    3,    1,    1'b0, 8,    2);
    runBeat("negwrap",  3,    5,    1,    1'b0, 8,    3327);
    runBeat("maxin",    3328, 3328, 7,    1'b0, 3327, 0);
    runBeat("zetamax",  0,    1,    3328, 1'b0, 1,    1);
    runBeat("zeta17",   10,   0,    17,   1'b0, 10,   170);
    runBeat("mixed",    1000, 2000, 1234, 1'b0, 3000, 1059);
`ifdef INTT_SCALE_EN
    runBeat("scale_on",  1, 0, 1, 1'b1, 3303, 3303);
    runBeat("scale_off", 1, 0, 1, 1'b0, 1,    1);
`endif

    // 8 back-to-back beats with the sink stalled for 3 cycles; beat k gives oA=100+11k, oB=2*(100+9k)
    sent = 0; rcvd = 0; stalled_prev = 1'b0; held_a = '0;
    for (int cyc = 0; cyc < 80 && rcvd < 8; cyc++) begin
      if (sent < 8) applyStimulus(100 + 10 * sent, sent, 2, 1'b0);
      else iValid = 1'b0;
      iReady = !(cyc >= 5 && cyc < 8);
      #1;
      if (oValid === 1'b1 && iReady === 1'b0) begin
        checkOutput("stream_full_ready", 32'(oReady), 32'd0);
        if (stalled_prev) checkOutput("stream_hold_oA", 32'(oA), 32'(held_a));
        held_a = oA;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (oValid === 1'b1 && iReady === 1'b1) begin
        checkOutput("stream_oA", 32'(oA), 32'(100 + 11 * rcvd));
        checkOutput("stream_oB", 32'(oB), 32'(2 * (100 + 9 * rcvd)));
        rcvd++;
      end
      if (iValid === 1'b1 && oReady === 1'b1) sent++;
      step();
    end
    iValid = 1'b0;
    iReady = 1'b1;
    checkOutput("stream_sent", 32'(sent), 32'd8);
    checkOutput("stream_received", 32'(rcvd), 32'd8);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (oValid !== 1'b0) seen++;
      step();
    end
    checkOutput("stream_no_extra", 32'(seen), 32'd0);
    checkOutput("stream_idle_busy", 32'(oBusy), 32'd0);

    // two beats in flight, then a one-cycle reset must discard both
    applyStimulus(7, 2, 5, 1'b0);
    step();
    applyStimulus(9, 4, 6, 1'b0);
    step();
    iValid = 1'b0;
    checkOutput("inflight_busy", 32'(oBusy), 32'd1);
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    checkOutput("midrst_oValid", 32'(oValid), 32'd0);
    checkOutput("midrst_oBusy", 32'(oBusy), 32'd0);
    checkOutput("midrst_oReady", 32'(oReady), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (oValid !== 1'b0) seen++;
    end
    checkOutput("midrst_no_stale", 32'(seen), 32'd0);

    runBeat("after_rst", 20, 30, 4, 1'b0, 50, 3289);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
